// File: rtl/pc_fetch_unit.sv
// Program-counter register and fetch sequencer: holds the PC, issues fetch
// requests to instruction memory and loads either PC+4 or a redirect target.
module pc_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] next_pc_seq,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_reg_out,
  output logic            imem_req,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [31:0]     fetch_count,
  output logic            misaligned_err
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    w_pc_nxt;
  logic               r_fetch_valid;
  logic               w_fetch_valid_nxt;
  logic [XLEN-1:0]    r_fetch_pc;
  logic [XLEN-1:0]    w_fetch_pc_nxt;
  logic [CNT_W-1:0]   r_fetch_count;
  logic [CNT_W-1:0]   w_fetch_count_nxt;
  logic               r_misaligned;
  logic               w_misaligned_nxt;
  logic               w_imem_req;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      r_fetch_pc    <= '0;
      r_fetch_count <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_fetch_count <= w_fetch_count_nxt;
      r_misaligned  <= w_misaligned_nxt;
    end
  end

  // Next-state: misaligned redirect > redirect > accepted fetch > hold
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_fetch_valid_nxt = 1'b0;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_fetch_count_nxt = r_fetch_count;
    w_misaligned_nxt  = r_misaligned;
    w_imem_req        = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_imem_req = ~stall;
        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          w_state_nxt      = ST_TRAP;
          w_misaligned_nxt = 1'b1;
        end else if (branch_taken) begin
          // Redirect discards the in-flight address even if memory accepted it
          w_pc_nxt = branch_target;
        end else if (w_imem_req && imem_ready) begin
          w_pc_nxt          = next_pc_seq;
          w_fetch_valid_nxt = 1'b1;
          w_fetch_pc_nxt    = r_pc;
          w_fetch_count_nxt = r_fetch_count + CNT_W'(1);
        end
      end
      ST_TRAP: begin
        w_state_nxt = ST_TRAP;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign pc_reg_out     = r_pc;
  assign imem_req       = w_imem_req;
  assign fetch_valid    = r_fetch_valid;
  assign fetch_pc       = r_fetch_pc;
  assign fetch_count    = r_fetch_count;
  assign misaligned_err = r_misaligned;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc_seq;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc_reg_out;
  logic        imem_req;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_count;
  logic        misaligned_err;

  int n_checks;
  int n_errors;

  // Reference model: mode 0 = booting, 1 = fetching, 2 = trapped
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_fv;
  logic [31:0] m_fpc;
  logic [31:0] m_cnt;
  logic        m_err;

  pc_fetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .next_pc_seq    (next_pc_seq),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall          (stall),
    .imem_ready     (imem_ready),
    .pc_reg_out     (pc_reg_out),
    .imem_req       (imem_req),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_count    (fetch_count),
    .misaligned_err (misaligned_err)
  );

  // Stands in for the external PC+4 adder
  assign next_pc_seq = pc_reg_out + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = RV;
    m_fv   = 1'b0;
    m_fpc  = 32'h0;
    m_cnt  = 32'h0;
    m_err  = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".pc"},          pc_reg_out,              m_pc);
    check_eq({ctx, ".imem_req"},    {31'h0, imem_req},       {31'h0, (m_mode == 1) && !stall});
    check_eq({ctx, ".fetch_valid"}, {31'h0, fetch_valid},    {31'h0, m_fv});
    check_eq({ctx, ".fetch_pc"},    fetch_pc,                m_fpc);
    check_eq({ctx, ".fetch_count"}, fetch_count,             m_cnt);
    check_eq({ctx, ".misaligned"},  {31'h0, misaligned_err}, {31'h0, m_err});
  endtask

  // Apply one cycle of inputs, check the combinational request, then the edge result
  task automatic step(input string ctx, input logic bt, input logic [31:0] tgt,
                      input logic st, input logic rdy);
    logic req;
    branch_taken  = bt;
    branch_target = tgt;
    stall         = st;
    imem_ready    = rdy;
    #1;
    req = (m_mode == 1) && !st;
    check_eq({ctx, ".req_pre"}, {31'h0, imem_req}, {31'h0, req});
    if (m_mode == 0) begin
      m_mode = 1;
      m_fv   = 1'b0;
    end else if (m_mode == 1) begin
      if (bt && (tgt % 4 != 0)) begin
        m_mode = 2;
        m_err  = 1'b1;
        m_fv   = 1'b0;
      end else if (bt) begin
        m_pc = tgt;
        m_fv = 1'b0;
      end else if (req && rdy) begin
        m_fv  = 1'b1;
        m_fpc = m_pc;
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_fv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  // Reset asserted between edges must take effect without a clock edge
  task automatic apply_reset(input string ctx);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    stall         = 1'b0;
    imem_ready    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Boot cycle then three sequential accepts
    for (int i = 0; i < 4; i++) step("seq", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("seq.count3", fetch_count, 32'd3);
    check_eq("seq.pc12", pc_reg_out, 32'd12);

    // Memory not ready: PC and count hold
    for (int i = 0; i < 3; i++) step("notready", 1'b0, 32'h0, 1'b0, 1'b0);

    // Aligned redirect with ready high: no fetch accepted
    step("redir", 1'b1, 32'h100, 1'b0, 1'b1);
    step("redir_next", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("redir.fetch_pc", fetch_pc, 32'h100);

    // Redirect while stalled still applies
    step("redir_stall", 1'b1, 32'h200, 1'b1, 1'b1);

    // Misaligned redirect traps until reset
    step("mis", 1'b1, 32'h102, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("trap", 1'b0, 32'h0, 1'b0, 1'(i % 2));
    step("trap_br", 1'b1, 32'h300, 1'b0, 1'b1);
    apply_reset("trap_rst");
    step("reboot", 1'b0, 32'h0, 1'b0, 1'b1);

    // Stall with ready high at 0x20, then resume
    step("to20", 1'b1, 32'h20, 1'b0, 1'b1);
    step("stall", 1'b0, 32'h0, 1'b1, 1'b1);
    step("stall", 1'b0, 32'h0, 1'b1, 1'b1);
    step("resume", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("resume.pc24", pc_reg_out, 32'h24);

    // PC wrap at top of address space, then mid-cycle reset
    step("toTop", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    step("wrap", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("wrap.pc0", pc_reg_out, 32'h0);
    check_eq("wrap.fpc", fetch_pc, 32'hFFFF_FFFC);
    step("post_wrap", 1'b0, 32'h0, 1'b0, 1'b1);
    apply_reset("midrst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int          r;
      logic        bt;
      logic        st;
      logic        rdy;
      logic [31:0] tgt;
      r   = int'($urandom_range(0, 99));
      bt  = (r < 14);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tgt = $urandom();
      tgt[1:0] = (r < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (r >= 97) apply_reset("rnd_rst");
      else step("rnd", bt, tgt, st, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
